// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types used by the fetch stage.
package cpu_pkg;

    localparam int unsigned     CPU_XLEN     = 32;
    localparam int unsigned     CPU_ILEN     = 32;
    localparam logic [31:0]     CPU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     PC_INC       = 32'd4;

    typedef enum logic {
        StFetch,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// In-order allocate-at-issue buffer pairing fetch PCs with their returning instruction words.
module fetch_buffer import cpu_pkg::*; #(
    parameter int unsigned XLEN  = CPU_XLEN,
    parameter int unsigned ILEN  = CPU_ILEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alloc_i,
    input  logic [XLEN-1:0]          alloc_pc_i,
    input  logic                     fill_i,
    input  logic [ILEN-1:0]          fill_instr_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   outstanding_o,
    output logic                     head_valid_o,
    output logic [XLEN-1:0]          head_pc_o,
    output logic [ILEN-1:0]          head_instr_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0]  alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [ILEN-1:0]  instr_q [DEPTH];

    logic [IdxW-1:0] alloc_idx, fill_idx, head_idx;

    assign alloc_idx = alloc_q[IdxW-1:0];
    assign fill_idx  = fill_q[IdxW-1:0];
    assign head_idx  = head_q[IdxW-1:0];

    always_comb begin
        alloc_d  = alloc_q;
        fill_d   = fill_q;
        head_d   = head_q;
        filled_d = filled_q;
        if (flush_i) begin
            alloc_d  = '0;
            fill_d   = '0;
            head_d   = '0;
            filled_d = '0;
        end else begin
            if (alloc_i) begin
                alloc_d             = alloc_q + PtrW'(1);
                filled_d[alloc_idx] = 1'b0;
            end
            if (fill_i) begin
                fill_d             = fill_q + PtrW'(1);
                filled_d[fill_idx] = 1'b1;
            end
            if (pop_i) begin
                head_d             = head_q + PtrW'(1);
                filled_d[head_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            head_q   <= '0;
            filled_q <= '0;
        end else begin
            alloc_q  <= alloc_d;
            fill_q   <= fill_d;
            head_q   <= head_d;
            filled_q <= filled_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (alloc_i) pc_q[alloc_idx]   <= alloc_pc_i;
            if (fill_i)  instr_q[fill_idx] <= fill_instr_i;
        end
    end

    assign full_o        = (alloc_q - head_q) >= PtrW'(DEPTH);
    assign outstanding_o = alloc_q - fill_q;
    assign head_valid_o  = filled_q[head_idx] && (head_q != fill_q);
    assign head_pc_o     = pc_q[head_idx];
    assign head_instr_o  = instr_q[head_idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory reads and hands PC/instr pairs
// to decode. Redirects flush the buffer and drain responses still in flight.
module fetch_unit import cpu_pkg::*; #(
    parameter int unsigned     XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC),
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] current_instr
);

    localparam int unsigned PtrW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [PtrW-1:0] drop_q, drop_d;

    logic            buf_full, head_valid;
    logic [PtrW-1:0] outstanding;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            req_fire, fill_hit, drop_hit, pop;

    assign req_fire = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are spurious (e.g. memory reset alongside us).
    assign fill_hit = imem_resp_valid && (drop_q == '0) && (outstanding != '0);
    assign drop_hit = imem_resp_valid && (drop_q != '0);
    assign pop      = head_valid && out_ready;

    fetch_buffer #(
        .XLEN  (XLEN),
        .ILEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk_i         (clk),
        .rst_i         (reset),
        .alloc_i       (req_fire),
        .alloc_pc_i    (pc_q),
        .fill_i        (fill_hit),
        .fill_instr_i  (imem_resp_data),
        .pop_i         (pop),
        .flush_i       (redirect_valid),
        .full_o        (buf_full),
        .outstanding_o (outstanding),
        .head_valid_o  (head_valid),
        .head_pc_o     (head_pc),
        .head_instr_o  (head_instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q - PtrW'(drop_hit);
        if (redirect_valid) begin
            // Everything still unanswered becomes stale, except a response landing this cycle.
            drop_d = drop_d + outstanding - PtrW'(fill_hit);
            pc_d   = redirect_pc & ~XLEN'(3);
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(PC_INC);
        end

        state_d = state_q;
        unique case (state_q)
            StFetch: state_d = StFetch;
            StDrain: if (drop_d == '0) state_d = StFetch;
            default: state_d = StFetch;
        endcase
        if (redirect_valid) state_d = (drop_d != '0) ? StDrain : StFetch;
    end

    always_comb begin
        imem_req_valid = !reset && (state_q == StFetch) && !buf_full && !redirect_valid;
        imem_req_addr  = pc_q;
        out_valid      = head_valid;
        current_pc     = head_valid ? head_pc : '0;
        current_instr  = head_valid ? head_instr : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model, queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] current_pc, current_instr;

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .current_pc      (current_pc),
        .current_instr   (current_instr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // Memory environment
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t       mem_q[$];
    logic [31:0] acc_log[$];
    int          lat = 1;
    int          cyc = 0;
    int          cnt8 = 0;

    // Reference model: in-order PCs awaiting delivery; the first nf of them have data.
    logic [31:0] mq[$];
    int          nf = 0;
    int          drop = 0;
    logic [31:0] mpc = RST_PC;

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                mem_q.delete();
                imem_resp_valid = 1'b0;
            end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                check("rst_out_valid", {31'b0, out_valid}, 32'd0);
                check("rst_req_addr", imem_req_addr, RST_PC);
                mq.delete();
                nf   = 0;
                drop = 0;
                mpc  = RST_PC;
            end else begin
                bit exp_req, exp_ov, acc, pop;
                exp_req = (drop == 0) && (mq.size() < DEPTH) && !redirect_valid;
                exp_ov  = (nf > 0);
                check("cyc_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
                if (exp_req) check("cyc_req_addr", imem_req_addr, mpc);
                check("cyc_out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
                if (exp_ov) begin
                    check("cyc_current_pc", current_pc, mq[0]);
                    check("cyc_current_instr", current_instr, mem_word(mq[0]));
                end
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                    acc_log.push_back(imem_req_addr);
                end
                if (out_valid && out_ready && current_pc == 32'h8) cnt8++;

                acc = exp_req && imem_req_ready;
                pop = exp_ov && out_ready;
                if (imem_resp_valid) begin
                    if (drop > 0) drop--;
                    else if (nf < mq.size()) nf++;
                end
                if (pop) begin
                    void'(mq.pop_front());
                    nf--;
                end
                if (acc) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
                if (redirect_valid) begin
                    drop = drop + (mq.size() - nf);
                    mq.delete();
                    nf  = 0;
                    mpc = redirect_pc & ~32'd3;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        step(2);
        reset = 1'b0;
        acc_log.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        bit found;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("in_reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("in_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("in_reset_current_pc", current_pc, 32'h0);
        check("in_reset_current_instr", current_instr, 32'h0);
        check("in_reset_req_addr", imem_req_addr, RST_PC);

        // Streaming with L=1
        do_reset();
        #1;
        check("p1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("p1_first_req_addr", imem_req_addr, 32'h0);
        step(2);
        #1;
        check("p1_c2_out_valid", {31'b0, out_valid}, 32'd1);
        check("p1_c2_current_pc", current_pc, 32'h0);
        check("p1_c2_current_instr", current_instr, 32'h0F0F_C3C3);
        for (int i = 0; i < 8; i++) begin
            imem_req_ready = i[0];
            step(1);
        end
        imem_req_ready = 1'b1;
        step(6);

        // Back-pressure from decode
        out_ready = 1'b0;
        do_reset();
        step(5);
        #1;
        check("p2_req_count", acc_log.size(), 32'd2);
        check("p2_req_stalled", {31'b0, imem_req_valid}, 32'd0);
        check("p2_head_valid", {31'b0, out_valid}, 32'd1);
        check("p2_head_pc", current_pc, 32'h0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            found = (acc_log.size() >= 3);
        end
        check("p2_resume_seen", {31'b0, found}, 32'd1);
        if (found) check("p2_resume_addr", acc_log[2], 32'h8);
        step(6);

        // Redirect with two stale requests in flight (L=3)
        lat = 3;
        do_reset();
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        #1;
        check("p3_drain_c3", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        #1;
        check("p3_drain_c4", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        #1;
        check("p3_refetch_valid", {31'b0, imem_req_valid}, 32'd1);
        check("p3_refetch_addr", imem_req_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            #1;
            found = out_valid;
        end
        check("p3_target_delivered", {31'b0, found}, 32'd1);
        check("p3_target_pc", current_pc, 32'h100);
        step(3);

        // Misaligned redirect target, nothing in flight
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        check("p4_redirect_blocks_req", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        check("p4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("p4_req_addr", imem_req_addr, 32'h200);
        step(4);

        // Redirect coincident with pop of pc 0x8 and a live response
        do_reset();
        cnt8  = 0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1);
            #1;
            found = out_valid && (current_pc == 32'h8) && imem_resp_valid;
        end
        check("p5_setup_seen", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        #1;
        check("p5_no_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("p5_req_addr", imem_req_addr, 32'h300);
        check("p5_flushed_out_valid", {31'b0, out_valid}, 32'd0);
        step(6);
        check("p5_pc8_consumed_once", cnt8, 32'd1);

        // PC wrap, then asynchronous reset mid-stream
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step(1);
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            found = (acc_log.size() >= 3);
        end
        check("p6_three_reqs", {31'b0, found}, 32'd1);
        if (found) begin
            check("p6_addr0", acc_log[0], 32'hFFFF_FFF8);
            check("p6_addr1", acc_log[1], 32'hFFFF_FFFC);
            check("p6_addr_wrap", acc_log[2], 32'h0000_0000);
        end
        out_ready = 1'b0;
        step(6);
        #1;
        check("p6_full_before_reset", {31'b0, out_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("p6_async_out_valid", {31'b0, out_valid}, 32'd0);
        check("p6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("p6_async_current_pc", current_pc, 32'h0);
        step(2);
        reset = 1'b0;
        acc_log.delete();
        #1;
        check("p6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        check("p6_restart_addr", imem_req_addr, RST_PC);
        out_ready = 1'b1;
        step(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
